// File: rtl/id_ex_stage_pkg.sv
// Shared CPU datapath constants, ALU op encodings and the ID/EX register layout.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

  // Everything the execute stage needs about one instruction.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic [OP_W-1:0]   alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_reg_t;

  // A bubble is all-zero: alu_op = AND and every write enable off.
  localparam ex_reg_t EX_BUBBLE = '0;

  // Regfile read bypass: a same-cycle WB write to the register being read wins.
  function automatic logic [DATA_W-1:0] wb_bypass(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_val,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    return (wb_we && (wb_rd != '0) && (wb_rd == addr)) ? wb_data : rf_val;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/forwarding bus into the ID/EX stage and its execute-side outputs.
interface id_ex_stage_if;
  import cpu_pkg::*;

  // decode slot
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [OP_W-1:0]   id_alu_op;
  logic              id_alu_src;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  // pipeline control
  logic              stall;
  logic              flush;
  // later-stage writeback sources
  logic [REG_AW-1:0] mem_rd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_res;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_we;
  logic [DATA_W-1:0] wb_data;
  // execute side
  logic [DATA_W-1:0] num1;
  logic [DATA_W-1:0] num2;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] ex_store;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_valid;
  logic              hazard_hold;

  modport master (
    output id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           stall, flush, mem_rd, mem_we, mem_res, wb_rd, wb_we, wb_data,
    input  num1, num2, alu_op, ex_store, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_valid, hazard_hold
  );

  modport slave (
    input  id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           stall, flush, mem_rd, mem_we, mem_res, wb_rd, wb_we, wb_data,
    output num1, num2, alu_op, ex_store, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_valid, hazard_hold
  );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Per-operand forwarding mux: newest in-flight write to the source register wins.
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_val,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_we,
  input  logic [DW-1:0] mem_res,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] fwd_val
);

  logic mem_hit;
  logic wb_hit;

  // EX/MEM is younger than MEM/WB so it takes precedence; $0 is never forwarded.
  always_comb begin
    mem_hit = mem_we && (mem_rd != '0) && (mem_rd == src_addr);
    wb_hit  = wb_we  && (wb_rd  != '0) && (wb_rd  == src_addr);
    fwd_val = src_val;
    if (mem_hit)     fwd_val = mem_res;
    else if (wb_hit) fwd_val = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and operand forwarding.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  ex_reg_t           ex_q;
  ex_reg_t           ex_d;
  ex_reg_t           load_d;
  logic              rs_dep;
  logic              rt_dep;
  logic              hazard;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Load-use detect: a load in EX whose destination the decode slot reads.
  // rt only counts when it is actually consumed: as the ALU operand, or as
  // store data (a store uses imm for the ALU but still needs rt).
  always_comb begin
    rs_dep = (ex_q.rd == bus.id_rs);
    rt_dep = (ex_q.rd == bus.id_rt) && (!bus.id_alu_src || bus.id_mem_write);
    hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
             (rs_dep || rt_dep);
  end

  // A flush already kills the slot, so upstream need not hold for it.
  assign bus.hazard_hold = rst_n & hazard & ~bus.flush;

  // Decode slot as it would be captured, with the regfile write-through bypass.
  always_comb begin
    load_d           = EX_BUBBLE;
    load_d.valid     = bus.id_valid;
    load_d.rd        = bus.id_rd;
    load_d.rs        = bus.id_rs;
    load_d.rt        = bus.id_rt;
    load_d.rs_val    = wb_bypass(bus.id_rs, bus.id_rs_val, bus.wb_we, bus.wb_rd, bus.wb_data);
    load_d.rt_val    = wb_bypass(bus.id_rt, bus.id_rt_val, bus.wb_we, bus.wb_rd, bus.wb_data);
    load_d.imm       = bus.id_imm;
    load_d.alu_op    = bus.id_alu_op;
    load_d.alu_src   = bus.id_alu_src;
    load_d.reg_write = bus.id_reg_write & bus.id_valid;
    load_d.mem_read  = bus.id_mem_read  & bus.id_valid;
    load_d.mem_write = bus.id_mem_write & bus.id_valid;
  end

  // Next register contents: flush > stall > load-use bubble > normal capture.
  always_comb begin
    ex_d = load_d;
    if (bus.flush)      ex_d = EX_BUBBLE;
    else if (bus.stall) ex_d = ex_q;
    else if (hazard)    ex_d = EX_BUBBLE;
  end

  // Pipeline register; reset leaves a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= EX_BUBBLE;
    else        ex_q <= ex_d;
  end

  fwd_sel u_fwd_rs (
    .src_addr (ex_q.rs),
    .src_val  (ex_q.rs_val),
    .mem_rd   (bus.mem_rd),
    .mem_we   (bus.mem_we),
    .mem_res  (bus.mem_res),
    .wb_rd    (bus.wb_rd),
    .wb_we    (bus.wb_we),
    .wb_data  (bus.wb_data),
    .fwd_val  (fwd_rs)
  );

  fwd_sel u_fwd_rt (
    .src_addr (ex_q.rt),
    .src_val  (ex_q.rt_val),
    .mem_rd   (bus.mem_rd),
    .mem_we   (bus.mem_we),
    .mem_res  (bus.mem_res),
    .wb_rd    (bus.wb_rd),
    .wb_we    (bus.wb_we),
    .wb_data  (bus.wb_data),
    .fwd_val  (fwd_rt)
  );

  assign bus.num1         = fwd_rs;
  assign bus.num2         = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign bus.ex_store     = fwd_rt;
  assign bus.alu_op       = ex_q.alu_op;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.ex_valid     = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios plus random traffic.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        id_valid;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  op;
    logic        src, rw, mr, mw, stall, flush;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic [31:0] mem_res;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
  } stim_t;

  // Instruction sitting in EX, as the reference model sees it.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd, rs, rt;
    logic [31:0] rs_val, rt_val, imm;
    logic [2:0]  op;
    logic        src, rw, mr, mw;
  } instr_t;

  typedef struct packed {
    logic [31:0] num1, num2;
    logic [2:0]  op;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw, mr, mw, valid, hh;
  } obs_t;

  typedef struct {
    string       name;
    int          fld;
    logic [31:0] val;
  } dchk_t;

  obs_t   sbq[$];
  dchk_t  dq[$];
  int     errors = 0;
  int     checks = 0;
  instr_t mdl, mdl_next;
  logic   known = 1'b0, next_known = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, id_valid: 1'b0, rs_val: 32'h0, rt_val: 32'h0, imm: 32'h0,
          rs: 5'd0, rt: 5'd0, rd: 5'd0, op: 3'd0, src: 1'b0, rw: 1'b0, mr: 1'b0,
          mw: 1'b0, stall: 1'b0, flush: 1'b0, mem_rd: 5'd0, mem_we: 1'b0,
          mem_res: 32'h0, wb_rd: 5'd0, wb_we: 1'b0, wb_data: 32'h0};
    return s;
  endfunction

  // The consumer in ID needs a value the load in EX has not produced yet.
  function automatic logic load_use(instr_t e, stim_t s);
    logic reads_rt;
    reads_rt = !s.src || s.mw;
    return e.valid && e.mr && e.rd != 0 && s.id_valid &&
           (e.rd == s.rs || (reads_rt && e.rd == s.rt));
  endfunction

  // Value of register r as seen in EX: the youngest pending writer, else the latched copy.
  function automatic logic [31:0] newest(logic [4:0] r, logic [31:0] latched, stim_t s);
    if (r == 0) return latched;
    if (s.mem_we && s.mem_rd == r) return s.mem_res;
    if (s.wb_we && s.wb_rd == r) return s.wb_data;
    return latched;
  endfunction

  function automatic obs_t predict(instr_t e, stim_t s);
    obs_t o;
    logic [31:0] rt_now;
    rt_now  = newest(e.rt, e.rt_val, s);
    o.num1  = newest(e.rs, e.rs_val, s);
    o.num2  = e.src ? e.imm : rt_now;
    o.store = rt_now;
    o.op    = e.op;
    o.rd    = e.rd;
    o.rw    = e.rw;
    o.mr    = e.mr;
    o.mw    = e.mw;
    o.valid = e.valid;
    o.hh    = s.rst_n && !s.flush && load_use(e, s);
    return o;
  endfunction

  function automatic instr_t advance(instr_t e, stim_t s);
    instr_t n;
    if (!s.rst_n || s.flush) return '0;
    if (s.stall) return e;
    if (load_use(e, s)) return '0;
    n.valid  = s.id_valid;
    n.rd     = s.rd;
    n.rs     = s.rs;
    n.rt     = s.rt;
    n.rs_val = (s.wb_we && s.wb_rd != 0 && s.wb_rd == s.rs) ? s.wb_data : s.rs_val;
    n.rt_val = (s.wb_we && s.wb_rd != 0 && s.wb_rd == s.rt) ? s.wb_data : s.rt_val;
    n.imm    = s.imm;
    n.op     = s.op;
    n.src    = s.src;
    n.rw     = s.rw & s.id_valid;
    n.mr     = s.mr & s.id_valid;
    n.mw     = s.mw & s.id_valid;
    return n;
  endfunction

  task automatic drive(stim_t s);
    rst_n            = s.rst_n;
    bus.id_valid     = s.id_valid;
    bus.id_rs_val    = s.rs_val;
    bus.id_rt_val    = s.rt_val;
    bus.id_imm       = s.imm;
    bus.id_rs        = s.rs;
    bus.id_rt        = s.rt;
    bus.id_rd        = s.rd;
    bus.id_alu_op    = s.op;
    bus.id_alu_src   = s.src;
    bus.id_reg_write = s.rw;
    bus.id_mem_read  = s.mr;
    bus.id_mem_write = s.mw;
    bus.stall        = s.stall;
    bus.flush        = s.flush;
    bus.mem_rd       = s.mem_rd;
    bus.mem_we       = s.mem_we;
    bus.mem_res      = s.mem_res;
    bus.wb_rd        = s.wb_rd;
    bus.wb_we        = s.wb_we;
    bus.wb_data      = s.wb_data;
  endtask

  // One cycle: advance the model at the edge, apply inputs, queue the expectation.
  task automatic step(stim_t s);
    @(posedge clk);
    mdl   = mdl_next;
    known = next_known;
    #1;
    drive(s);
    if (known) sbq.push_back(predict(mdl, s));
    mdl_next   = advance(mdl, s);
    next_known = known || !s.rst_n;
  endtask

  task automatic dexp(string n, int fld, logic [31:0] v);
    dchk_t d;
    d.name = n;
    d.fld  = fld;
    d.val  = v;
    dq.push_back(d);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.num1  = bus.num1;
    o.num2  = bus.num2;
    o.op    = bus.alu_op;
    o.store = bus.ex_store;
    o.rd    = bus.ex_rd;
    o.rw    = bus.ex_reg_write;
    o.mr    = bus.ex_mem_read;
    o.mw    = bus.ex_mem_write;
    o.valid = bus.ex_valid;
    o.hh    = bus.hazard_hold;
    return o;
  endfunction

  function automatic logic [31:0] field(obs_t o, int f);
    case (f)
      0:       return o.num1;
      1:       return o.num2;
      2:       return {29'd0, o.op};
      3:       return {31'd0, o.valid};
      4:       return {31'd0, o.rw};
      5:       return {31'd0, o.hh};
      default: return o.store;
    endcase
  endfunction

  // Monitor: compares DUT outputs mid-cycle against whatever the stimulus queued.
  initial begin
    obs_t  a, e;
    dchk_t d;
    forever begin
      @(negedge clk);
      a = sample();
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_obs t=%0t got n1=%h n2=%h op=%h st=%h rd=%0d rw=%b mr=%b mw=%b v=%b hh=%b want n1=%h n2=%h op=%h st=%h rd=%0d rw=%b mr=%b mw=%b v=%b hh=%b",
                   $time, a.num1, a.num2, a.op, a.store, a.rd, a.rw, a.mr, a.mw, a.valid, a.hh,
                   e.num1, e.num2, e.op, e.store, e.rd, e.rw, e.mr, e.mw, e.valid, e.hh);
        end
      end
      while (dq.size() > 0) begin
        d = dq.pop_front();
        checks++;
        if (field(a, d.fld) !== d.val) begin
          errors++;
          $display("FAIL %s t=%0t got=%h want=%h", d.name, $time, field(a, d.fld), d.val);
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [2:0] ops [5];
    ops[0] = ALU_AND; ops[1] = ALU_OR; ops[2] = ALU_ADD; ops[3] = ALU_SUB; ops[4] = ALU_SLT;
    s = idle();
    s.rst_n = 1'b0;
    drive(s);
    mdl = '0;
    mdl_next = '0;

    // reset held two cycles with a valid slot presented
    s = idle(); s.rst_n = 1'b0; s.id_valid = 1'b1; s.rw = 1'b1; s.rd = 5'd3;
    step(s);
    step(s);
    dexp("rst_ex_valid", 3, 32'd0);
    dexp("rst_reg_write", 4, 32'd0);
    dexp("rst_hazard_hold", 5, 32'd0);

    // plain ADD, one-cycle latency
    s = idle(); s.id_valid = 1'b1; s.rs = 5'd1; s.rt = 5'd2; s.rs_val = 32'd5; s.rt_val = 32'd7;
    s.op = ALU_ADD; s.rw = 1'b1; s.rd = 5'd3;
    step(s);
    s = idle();
    step(s);
    dexp("add_num1", 0, 32'd5);
    dexp("add_num2", 1, 32'd7);
    dexp("add_op", 2, 32'(ALU_ADD));

    // EX/MEM beats MEM/WB, then MEM/WB alone
    s = idle(); s.id_valid = 1'b1; s.rs = 5'd3;
    step(s);
    s = idle(); s.stall = 1'b1; s.mem_rd = 5'd3; s.mem_we = 1'b1; s.mem_res = 32'h11;
    s.wb_rd = 5'd3; s.wb_we = 1'b1; s.wb_data = 32'h22;
    step(s);
    dexp("fwd_mem_wins", 0, 32'h11);
    s.mem_we = 1'b0;
    step(s);
    dexp("fwd_wb", 0, 32'h22);

    // load-use: one held cycle, one bubble, then capture with WB bypass
    s = idle(); s.id_valid = 1'b1; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd4; s.rs = 5'd1; s.src = 1'b1;
    step(s);
    s = idle(); s.id_valid = 1'b1; s.rs = 5'd4; s.rt = 5'd5; s.rs_val = 32'hDEAD;
    s.rw = 1'b1; s.rd = 5'd6; s.op = ALU_ADD;
    step(s);
    dexp("lu_hold", 5, 32'd1);
    s.wb_we = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'h99;
    step(s);
    dexp("lu_bubble", 3, 32'd0);
    dexp("lu_hold_clear", 5, 32'd0);
    s = idle();
    step(s);
    dexp("lu_num1", 0, 32'h99);
    dexp("lu_valid", 3, 32'd1);

    // flush over stall over hazard
    s = idle(); s.id_valid = 1'b1; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd4; s.src = 1'b1;
    step(s);
    s = idle(); s.id_valid = 1'b1; s.rs = 5'd4; s.stall = 1'b1; s.flush = 1'b1;
    step(s);
    dexp("flush_hold", 5, 32'd0);
    s = idle();
    step(s);
    dexp("flush_bubble", 3, 32'd0);

    // stall alone for three cycles holds an OR-immediate
    s = idle(); s.id_valid = 1'b1; s.rs = 5'd5; s.rs_val = 32'h1234; s.imm = 32'h55;
    s.src = 1'b1; s.op = ALU_OR; s.rw = 1'b1; s.rd = 5'd7;
    step(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1'b1; s.id_valid = 1'b1;
      s.rs = 5'($urandom_range(1, 7)); s.rs_val = $urandom; s.imm = $urandom; s.op = ops[$urandom_range(0, 4)];
      step(s);
      dexp("stall_num1", 0, 32'h1234);
      dexp("stall_num2", 1, 32'h55);
      dexp("stall_op", 2, 32'(ALU_OR));
    end

    // $0 guard and WB-to-ID bypass
    s = idle(); s.id_valid = 1'b1;
    step(s);
    s = idle(); s.stall = 1'b1; s.mem_we = 1'b1; s.mem_rd = 5'd0; s.mem_res = 32'hFF;
    step(s);
    dexp("r0_guard", 0, 32'd0);
    s = idle(); s.id_valid = 1'b1; s.rs = 5'd9; s.rs_val = 32'h1;
    s.wb_rd = 5'd9; s.wb_we = 1'b1; s.wb_data = 32'hAB;
    step(s);
    s = idle();
    step(s);
    dexp("wb_bypass", 0, 32'hAB);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      s = idle();
      s.rst_n    = ($urandom_range(0, 99) != 0);
      s.id_valid = ($urandom_range(0, 9) != 0);
      s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7)); s.rd = 5'($urandom_range(0, 7));
      s.rs_val = $urandom; s.rt_val = $urandom; s.imm = $urandom;
      s.op  = ops[$urandom_range(0, 4)];
      s.src = 1'($urandom_range(0, 1));
      s.mr  = ($urandom_range(0, 3) == 0);
      s.mw  = !s.mr && ($urandom_range(0, 3) == 0);
      s.rw  = s.mr || (!s.mw && $urandom_range(0, 1) == 1);
      s.stall = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.mem_rd = 5'($urandom_range(0, 7)); s.mem_we = 1'($urandom_range(0, 1)); s.mem_res = $urandom;
      s.wb_rd  = 5'($urandom_range(0, 7)); s.wb_we  = 1'($urandom_range(0, 1)); s.wb_data = $urandom;
      step(s);
    end

    step(idle());
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending want=0/0", sbq.size(), dq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
